// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage.
//   state_e    : MEM-stage controller states
//   op_e       : decoded memory operation
//   decode_op  : memread > memwrite, double > storeByte
//   byte_merge : replace one little-endian byte lane of a word
package mem_stage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        SB_MERGE,
        DL_HI,
        DL_WAIT,
        DS_HI
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LW,
        OP_SW,
        OP_SB,
        OP_LD,
        OP_SD
    } op_e;

    function automatic op_e decode_op(input logic memread,
                                      input logic memwrite,
                                      input logic store_byte,
                                      input logic dbl);
        op_e op;
        op = OP_NONE;
        if (memread) begin
            // A simultaneous memwrite is ignored: the access is a pure load.
            op = dbl ? OP_LD : OP_LW;
        end else if (memwrite) begin
            if (dbl) begin
                op = OP_SD;
            end else if (store_byte) begin
                op = OP_SB;
            end else begin
                op = OP_SW;
            end
        end
        return op;
    endfunction

    // Lane 0 is bits [7:0].
    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [7:0]  byte_val,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = byte_val;
            2'd1:    r[15:8]  = byte_val;
            2'd2:    r[23:16] = byte_val;
            default: r[31:24] = byte_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register.
//   load_i         : 1 = capture pass-through fields, 0 = bubble (clear write enables, hold rest)
//   mem_ld_i       : capture memdata_i into memdata_o (load completion)
//   dbl_ld_i       : capture memdata_double_i into memdata_double_o (double load completion)
//   *_i / *_o      : pass-through fields from the MEM stage / towards WB
// Synchronous active-low reset clears every field.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        mem_ld_i,
    input  logic        dbl_ld_i,
    input  logic [31:0] memdata_i,
    input  logic [31:0] memdata_double_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] result_alu_i,
    input  logic [31:0] result_alu_double_i,
    input  logic [31:0] shift_left16_i,
    input  logic [1:0]  memtoreg_i,
    input  logic [4:0]  writereg_i,
    input  logic        regwrite_i,
    input  logic        regwrite_f_i,
    output logic [31:0] memdata_o,
    output logic [31:0] memdata_double_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] result_alu_o,
    output logic [31:0] result_alu_double_o,
    output logic [31:0] shift_left16_o,
    output logic [1:0]  memtoreg_o,
    output logic [4:0]  writereg_o,
    output logic        regwrite_o,
    output logic        regwrite_f_o
);

    logic [31:0] memdata_d, memdata_q;
    logic [31:0] memdata_double_d, memdata_double_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic [31:0] result_alu_d, result_alu_q;
    logic [31:0] result_alu_double_d, result_alu_double_q;
    logic [31:0] shift_left16_d, shift_left16_q;
    logic [1:0]  memtoreg_d, memtoreg_q;
    logic [4:0]  writereg_d, writereg_q;
    logic        regwrite_d, regwrite_q;
    logic        regwrite_f_d, regwrite_f_q;

    always_comb begin
        memdata_d           = mem_ld_i ? memdata_i : memdata_q;
        memdata_double_d    = dbl_ld_i ? memdata_double_i : memdata_double_q;
        pc_plus4_d          = pc_plus4_q;
        result_alu_d        = result_alu_q;
        result_alu_double_d = result_alu_double_q;
        shift_left16_d      = shift_left16_q;
        memtoreg_d          = memtoreg_q;
        writereg_d          = writereg_q;
        // A bubble must never retire a register write.
        regwrite_d          = 1'b0;
        regwrite_f_d        = 1'b0;
        if (load_i) begin
            pc_plus4_d          = pc_plus4_i;
            result_alu_d        = result_alu_i;
            result_alu_double_d = result_alu_double_i;
            shift_left16_d      = shift_left16_i;
            memtoreg_d          = memtoreg_i;
            writereg_d          = writereg_i;
            regwrite_d          = regwrite_i;
            regwrite_f_d        = regwrite_f_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memdata_q           <= '0;
            memdata_double_q    <= '0;
            pc_plus4_q          <= '0;
            result_alu_q        <= '0;
            result_alu_double_q <= '0;
            shift_left16_q      <= '0;
            memtoreg_q          <= '0;
            writereg_q          <= '0;
            regwrite_q          <= 1'b0;
            regwrite_f_q        <= 1'b0;
        end else begin
            memdata_q           <= memdata_d;
            memdata_double_q    <= memdata_double_d;
            pc_plus4_q          <= pc_plus4_d;
            result_alu_q        <= result_alu_d;
            result_alu_double_q <= result_alu_double_d;
            shift_left16_q      <= shift_left16_d;
            memtoreg_q          <= memtoreg_d;
            writereg_q          <= writereg_d;
            regwrite_q          <= regwrite_d;
            regwrite_f_q        <= regwrite_f_d;
        end
    end

    assign memdata_o           = memdata_q;
    assign memdata_double_o    = memdata_double_q;
    assign pc_plus4_o          = pc_plus4_q;
    assign result_alu_o        = result_alu_q;
    assign result_alu_double_o = result_alu_double_q;
    assign shift_left16_o      = shift_left16_q;
    assign memtoreg_o          = memtoreg_q;
    assign writereg_o          = writereg_q;
    assign regwrite_o          = regwrite_q;
    assign regwrite_f_o        = regwrite_f_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller.
// Consumes the EXE/MEM register outputs, drives a single-port synchronous word memory
// (read data valid one cycle after the address) and owns the MEM/WB register.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   *_M                      : EXE/MEM fields (access controls, address, store data, pass-through)
//   stall_M                  : hold upstream while a multi-cycle access is in progress
//   mem_addr/mem_we/mem_wdata: memory request (combinational)
//   mem_rdata                : memory read data
//   *_W                      : MEM/WB register outputs
// Ops: LW 2 cycles, SW 1, SB 2 (read-merge-write), LD 3, SD 2.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread_M,
    input  logic              memwrite_M,
    input  logic              storeByte_M,
    input  logic              double_M,
    input  logic [31:0]       resultAlu_M,
    input  logic [31:0]       readdata2_M,
    input  logic [31:0]       readdata_double2_M,
    input  logic [31:0]       PC_plus4_M,
    input  logic [31:0]       ShiftLeft16_M,
    input  logic [31:0]       resultAlu_double_M,
    input  logic [1:0]        memtoreg_M,
    input  logic [4:0]        writereg_M,
    input  logic              regwrite_M,
    input  logic              regwriteF_M,
    output logic              stall_M,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       memdata_W,
    output logic [31:0]       memdata_double_W,
    output logic [31:0]       PC_plus4_W,
    output logic [31:0]       resultAlu_W,
    output logic [31:0]       resultAlu_double_W,
    output logic [31:0]       ShiftLeft16_W,
    output logic [1:0]        memtoreg_W,
    output logic [4:0]        writereg_W,
    output logic              regwrite_W,
    output logic              regwriteF_W
);

    state_e            state_d, state_q;
    logic [31:0]       lo_d, lo_q;
    op_e               op;
    logic [MEM_AW-1:0] word_a;
    logic [MEM_AW-1:0] word_a1;
    logic              mem_ld;
    logic              dbl_ld;
    logic [31:0]       ld_lo_val;
    logic              unused_addr_bits;

    assign op      = decode_op(memread_M, memwrite_M, storeByte_M, double_M);
    assign word_a  = resultAlu_M[MEM_AW+1:2];
    // Second word of a double wraps around the top of memory.
    assign word_a1 = word_a + {{(MEM_AW-1){1'b0}}, 1'b1};

    assign unused_addr_bits = ^resultAlu_M[31:MEM_AW+2];

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        stall_M   = 1'b0;
        mem_addr  = word_a;
        mem_we    = 1'b0;
        mem_wdata = readdata2_M;
        mem_ld    = 1'b0;
        dbl_ld    = 1'b0;
        ld_lo_val = mem_rdata;

        case (state_q)
            IDLE: begin
                case (op)
                    OP_LW: begin
                        stall_M = 1'b1;
                        state_d = LD_WAIT;
                    end
                    OP_SW: begin
                        mem_we = 1'b1;
                    end
                    OP_SB: begin
                        stall_M = 1'b1;
                        state_d = SB_MERGE;
                    end
                    OP_LD: begin
                        stall_M = 1'b1;
                        state_d = DL_HI;
                    end
                    OP_SD: begin
                        mem_we  = 1'b1;
                        stall_M = 1'b1;
                        state_d = DS_HI;
                    end
                    default: ;
                endcase
            end
            LD_WAIT: begin
                mem_ld  = 1'b1;
                state_d = IDLE;
            end
            SB_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = byte_merge(mem_rdata, readdata2_M[7:0], resultAlu_M[1:0]);
                state_d   = IDLE;
            end
            DL_HI: begin
                lo_d     = mem_rdata;
                mem_addr = word_a1;
                stall_M  = 1'b1;
                state_d  = DL_WAIT;
            end
            DL_WAIT: begin
                mem_ld    = 1'b1;
                dbl_ld    = 1'b1;
                ld_lo_val = lo_q;
                state_d   = IDLE;
            end
            DS_HI: begin
                mem_addr  = word_a1;
                mem_we    = 1'b1;
                mem_wdata = readdata_double2_M;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No memory side effects and no upstream hold while reset is asserted.
        if (!rst_n) begin
            mem_we  = 1'b0;
            stall_M = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk                 (clk),
        .rst_n               (rst_n),
        .load_i              (!stall_M),
        .mem_ld_i            (mem_ld),
        .dbl_ld_i            (dbl_ld),
        .memdata_i           (ld_lo_val),
        .memdata_double_i    (mem_rdata),
        .pc_plus4_i          (PC_plus4_M),
        .result_alu_i        (resultAlu_M),
        .result_alu_double_i (resultAlu_double_M),
        .shift_left16_i      (ShiftLeft16_M),
        .memtoreg_i          (memtoreg_M),
        .writereg_i          (writereg_M),
        .regwrite_i          (regwrite_M),
        .regwrite_f_i        (regwriteF_M),
        .memdata_o           (memdata_W),
        .memdata_double_o    (memdata_double_W),
        .pc_plus4_o          (PC_plus4_W),
        .result_alu_o        (resultAlu_W),
        .result_alu_double_o (resultAlu_double_W),
        .shift_left16_o      (ShiftLeft16_W),
        .memtoreg_o          (memtoreg_W),
        .writereg_o          (writereg_W),
        .regwrite_o          (regwrite_W),
        .regwrite_f_o        (regwriteF_W)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int unsigned MEM_AW = 10;

    logic              clk;
    logic              rst_n;
    logic              memread_M, memwrite_M, storeByte_M, double_M;
    logic [31:0]       resultAlu_M, readdata2_M, readdata_double2_M;
    logic [31:0]       PC_plus4_M, ShiftLeft16_M, resultAlu_double_M;
    logic [1:0]        memtoreg_M;
    logic [4:0]        writereg_M;
    logic              regwrite_M, regwriteF_M;
    logic              stall_M;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       memdata_W, memdata_double_W;
    logic [31:0]       PC_plus4_W, resultAlu_W, resultAlu_double_W, ShiftLeft16_W;
    logic [1:0]        memtoreg_W;
    logic [4:0]        writereg_W;
    logic              regwrite_W, regwriteF_W;

    // Bench-side memory with a preload port used only while the DUT is not writing.
    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic              pl_we;
    logic [MEM_AW-1:0] pl_addr;
    logic [31:0]       pl_data;

    int n_chk;
    int n_err;

    mem_stage_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .memread_M          (memread_M),
        .memwrite_M         (memwrite_M),
        .storeByte_M        (storeByte_M),
        .double_M           (double_M),
        .resultAlu_M        (resultAlu_M),
        .readdata2_M        (readdata2_M),
        .readdata_double2_M (readdata_double2_M),
        .PC_plus4_M         (PC_plus4_M),
        .ShiftLeft16_M      (ShiftLeft16_M),
        .resultAlu_double_M (resultAlu_double_M),
        .memtoreg_M         (memtoreg_M),
        .writereg_M         (writereg_M),
        .regwrite_M         (regwrite_M),
        .regwriteF_M        (regwriteF_M),
        .stall_M            (stall_M),
        .mem_addr           (mem_addr),
        .mem_we             (mem_we),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .memdata_W          (memdata_W),
        .memdata_double_W   (memdata_double_W),
        .PC_plus4_W         (PC_plus4_W),
        .resultAlu_W        (resultAlu_W),
        .resultAlu_double_W (resultAlu_double_W),
        .ShiftLeft16_W      (ShiftLeft16_W),
        .memtoreg_W         (memtoreg_W),
        .writereg_W         (writereg_W),
        .regwrite_W         (regwrite_W),
        .regwriteF_W        (regwriteF_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        memread_M          = 1'b0;
        memwrite_M         = 1'b0;
        storeByte_M        = 1'b0;
        double_M           = 1'b0;
        resultAlu_M        = 32'h0;
        readdata2_M        = 32'h0;
        readdata_double2_M = 32'h0;
        PC_plus4_M         = 32'h0;
        ShiftLeft16_M      = 32'h0;
        resultAlu_double_M = 32'h0;
        memtoreg_M         = 2'd0;
        writereg_M         = 5'd0;
        regwrite_M         = 1'b0;
        regwriteF_M        = 1'b0;
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        pl_we = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state
        tick();
        tick();
        memread_M = 1'b1;
        #1;
        chk("rst_stall", {31'b0, stall_M}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_memdata_W", memdata_W, 32'h0);
        chk("rst_pc_W", PC_plus4_W, 32'h0);
        chk("rst_regwrite_W", {31'b0, regwrite_W}, 32'd0);
        clear_inputs();
        preload(10'd5, 32'hDEADBEEF);
        rst_n = 1'b1;
        preload(10'd1, 32'h01010101);
        preload(10'd2, 32'h11223344);
        preload(10'd3, 32'h03030303);
        preload(10'd6, 32'h00000000);
        preload(10'd7, 32'h3FF00000);

        // 1. LW
        memread_M = 1'b1; resultAlu_M = 32'h14; writereg_M = 5'd8; regwrite_M = 1'b1;
        PC_plus4_M = 32'h204;
        #1;
        chk("lw_c1_stall", {31'b0, stall_M}, 32'd1);
        chk("lw_c1_addr", {22'b0, mem_addr}, 32'd5);
        chk("lw_c1_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("lw_bubble_regwrite_W", {31'b0, regwrite_W}, 32'd0);
        chk("lw_c2_stall", {31'b0, stall_M}, 32'd0);
        tick();
        chk("lw_memdata_W", memdata_W, 32'hDEADBEEF);
        chk("lw_writereg_W", {27'b0, writereg_W}, 32'd8);
        chk("lw_regwrite_W", {31'b0, regwrite_W}, 32'd1);
        chk("lw_pc_W", PC_plus4_W, 32'h204);
        clear_inputs();

        // 2. SB into lane 2 of word 2
        storeByte_M = 1'b1; memwrite_M = 1'b1; resultAlu_M = 32'h0A; readdata2_M = 32'hAB;
        #1;
        chk("sb_c1_stall", {31'b0, stall_M}, 32'd1);
        chk("sb_c1_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("sb_c2_stall", {31'b0, stall_M}, 32'd0);
        chk("sb_c2_we", {31'b0, mem_we}, 32'd1);
        chk("sb_c2_wdata", mem_wdata, 32'h11AB3344);
        tick();
        clear_inputs();
        #1;
        chk("sb_mem2", mem[2], 32'h11AB3344);
        chk("sb_mem1", mem[1], 32'h01010101);
        chk("sb_mem3", mem[3], 32'h03030303);
        chk("sb_memdata_hold", memdata_W, 32'hDEADBEEF);

        // 3. LD from words 6/7
        double_M = 1'b1; memread_M = 1'b1; resultAlu_M = 32'h18; regwriteF_M = 1'b1;
        #1;
        chk("ld_c1_stall", {31'b0, stall_M}, 32'd1);
        tick();
        chk("ld_c2_stall", {31'b0, stall_M}, 32'd1);
        chk("ld_c2_addr", {22'b0, mem_addr}, 32'd7);
        chk("ld_bubble_regwriteF_W", {31'b0, regwriteF_W}, 32'd0);
        tick();
        chk("ld_c3_stall", {31'b0, stall_M}, 32'd0);
        tick();
        chk("ld_memdata_W", memdata_W, 32'h0);
        chk("ld_memdata_double_W", memdata_double_W, 32'h3FF00000);
        chk("ld_regwriteF_W", {31'b0, regwriteF_W}, 32'd1);
        clear_inputs();

        // 4. SD wrapping from word 1023 to word 0
        double_M = 1'b1; memwrite_M = 1'b1; resultAlu_M = 32'hFFC;
        readdata2_M = 32'hAAAA5555; readdata_double2_M = 32'h12345678;
        #1;
        chk("sd_c1_stall", {31'b0, stall_M}, 32'd1);
        chk("sd_c1_we", {31'b0, mem_we}, 32'd1);
        chk("sd_c1_addr", {22'b0, mem_addr}, 32'd1023);
        tick();
        chk("sd_c2_stall", {31'b0, stall_M}, 32'd0);
        chk("sd_c2_addr", {22'b0, mem_addr}, 32'd0);
        chk("sd_c2_wdata", mem_wdata, 32'h12345678);
        tick();
        clear_inputs();
        #1;
        chk("sd_mem1023", mem[1023], 32'hAAAA5555);
        chk("sd_mem0", mem[0], 32'h12345678);
        chk("sd_double_hold", memdata_double_W, 32'h3FF00000);

        // 5. Stream ALU, SW, ALU, SW with no stalls
        regwrite_M = 1'b1; writereg_M = 5'd3; PC_plus4_M = 32'h100; resultAlu_M = 32'h77;
        memtoreg_M = 2'd1;
        #1;
        chk("st1_stall", {31'b0, stall_M}, 32'd0);
        chk("st1_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("st1_writereg_W", {27'b0, writereg_W}, 32'd3);
        chk("st1_resultAlu_W", resultAlu_W, 32'h77);
        chk("st1_memtoreg_W", {30'b0, memtoreg_W}, 32'd1);
        clear_inputs();
        memwrite_M = 1'b1; resultAlu_M = 32'h40; readdata2_M = 32'hCAFE0001; PC_plus4_M = 32'h104;
        #1;
        chk("st2_stall", {31'b0, stall_M}, 32'd0);
        chk("st2_we", {31'b0, mem_we}, 32'd1);
        chk("st2_addr", {22'b0, mem_addr}, 32'd16);
        tick();
        chk("st2_regwrite_W", {31'b0, regwrite_W}, 32'd0);
        chk("st2_pc_W", PC_plus4_W, 32'h104);
        chk("st2_mem16", mem[16], 32'hCAFE0001);
        clear_inputs();
        regwrite_M = 1'b1; writereg_M = 5'd4; PC_plus4_M = 32'h108; resultAlu_M = 32'h99;
        #1;
        chk("st3_stall", {31'b0, stall_M}, 32'd0);
        tick();
        chk("st3_writereg_W", {27'b0, writereg_W}, 32'd4);
        chk("st3_regwrite_W", {31'b0, regwrite_W}, 32'd1);
        clear_inputs();
        memwrite_M = 1'b1; resultAlu_M = 32'h44; readdata2_M = 32'hCAFE0002; PC_plus4_M = 32'h10C;
        #1;
        chk("st4_stall", {31'b0, stall_M}, 32'd0);
        chk("st4_we", {31'b0, mem_we}, 32'd1);
        tick();
        chk("st4_mem17", mem[17], 32'hCAFE0002);
        chk("st4_resultAlu_W", resultAlu_W, 32'h44);
        clear_inputs();

        // 6. Reset during DL_HI, then a clean LW
        double_M = 1'b1; memread_M = 1'b1; resultAlu_M = 32'h18; PC_plus4_M = 32'h300;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst6_stall_forced", {31'b0, stall_M}, 32'd0);
        chk("rst6_we_forced", {31'b0, mem_we}, 32'd0);
        tick();
        chk("rst6_memdata_W", memdata_W, 32'h0);
        chk("rst6_memdata_double_W", memdata_double_W, 32'h0);
        chk("rst6_pc_W", PC_plus4_W, 32'h0);
        chk("rst6_resultAlu_W", resultAlu_W, 32'h0);
        clear_inputs();
        rst_n = 1'b1;
        memread_M = 1'b1; resultAlu_M = 32'h14; writereg_M = 5'd9; regwrite_M = 1'b1;
        #1;
        chk("rst6_lw_c1_stall", {31'b0, stall_M}, 32'd1);
        chk("rst6_lw_c1_addr", {22'b0, mem_addr}, 32'd5);
        tick();
        chk("rst6_lw_c2_stall", {31'b0, stall_M}, 32'd0);
        tick();
        chk("rst6_lw_memdata_W", memdata_W, 32'hDEADBEEF);
        chk("rst6_lw_writereg_W", {27'b0, writereg_W}, 32'd9);
        chk("rst6_lw_regwrite_W", {31'b0, regwrite_W}, 32'd1);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
